// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Optional early termination of multiplies when MULDIV_EARLY_TERM_EN is defined.
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic               sign_a, sign_b, is_div, div_zero;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               op_signed, op_div, sa_in, sb_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_trial, div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign busy      = (state != IDLE);
  assign op_signed = ~op[0];
  assign op_div    = op[1];
  assign sa_in     = op_signed & a[WIDTH-1];
  assign sb_in     = op_signed & b[WIDTH-1];
  assign mag_a     = sa_in ? -a : a;
  assign mag_b     = sb_in ? -b : b;

  // Multiply: acc = {partial sum, multiplier}; add at the top, shift right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at the bottom.
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, opnd});
  assign div_rem   = div_ge ? (div_trial - {1'b0, opnd}) : div_trial;
  assign div_next  = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], div_ge};

  assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic             mul_zero;
  // Low cnt bits of acc still hold unconsumed multiplier bits.
  assign rem_mask = ~({WIDTH{1'b1}} << cnt);
  assign mul_zero = ~is_div && ((acc[WIDTH-1:0] & rem_mask) == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      opnd     <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start && !abort) begin
            is_div <= op_div;
            cnt    <= CNT_W'(WIDTH);
            if (op_div && (b == '0)) begin
              div_zero <= 1'b1;
              sign_a   <= 1'b0;
              sign_b   <= 1'b0;
              acc      <= {a, {WIDTH{1'b1}}};
              state    <= FIX;
            end else begin
              div_zero <= 1'b0;
              sign_a   <= sa_in;
              sign_b   <= sb_in;
              opnd     <= op_div ? mag_b : mag_a;
              acc      <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
              state    <= CALC;
            end
          end
        end
        CALC: begin
          if (abort) begin
            state <= IDLE;
          end else
`ifdef MULDIV_EARLY_TERM_EN
          if (mul_zero) begin
            acc   <= acc >> cnt;
            state <= FIX;
          end else
`endif
          begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= FIX;
          end
        end
        FIX: begin
          if (!abort) begin
            if (div_zero) begin
              {hi, lo} <= acc;
            end else if (is_div) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage. Consumes the ID/EX-registered operands (rs/rt values) and a decoded mul/div opcode.
- Computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over multiple cycles.
- Raises `busy` so the hazard unit can stall the front end while a result is pending. Also serves MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs value (multiplicand / dividend)
- b  input  WIDTH  rt value (multiplier / divisor)
- abort  input  1  cancel in-flight operation (EX flush)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight; combinational, state != IDLE
- done  output  1  one-cycle pulse; HI/LO hold the new result

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - hi=0, lo=0, done=0, busy=0.
  - Counter and working registers are cleared.
- States: IDLE, CALC, FIX.
- IDLE -> CALC: start=1 and abort=0 at a clock edge.
  - Latch sign flags: signed ops use a[WIDTH-1] and b[WIDTH-1]; unsigned ops use 0.
  - Latch operand magnitudes (two's-complement negate if the sign flag is set).
  - Load the counter with WIDTH.
- IDLE -> FIX directly: DIV/DIVU with b==0.
  - Result is hi=a (raw), lo={WIDTH{1'b1}}.
  - This fixed result is not sign-corrected.
- CALC, one iteration per cycle:
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - The counter decrements each cycle; on the cycle the counter reaches 1, go to FIX.
- FIX (single cycle): sign-correct the magnitude result, then write HI/LO and return to IDLE.
  - Product is negated if sign_a ^ sign_b.
  - Quotient is negated if sign_a ^ sign_b.
  - Remainder is negated if sign_a.
  - Multiply: hi = upper half, lo = lower half.
  - Divide: lo = quotient, hi = remainder.
  - done is registered: high exactly in the cycle after the FIX edge. busy is 0 in that cycle.
- Latency:
  - Start accepted at edge E0; busy=1 in cycles E0+1 .. E0+WIDTH+1.
  - done=1 and the new HI/LO are visible in cycle E0+WIDTH+2 (34 cycles for WIDTH=32).
  - Divide-by-zero: busy for 1 cycle, done in cycle E0+2.
- Arithmetic: the result is truncated to WIDTH per half. DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Boundary conditions:
  - start while busy: ignored, no effect on the in-flight operation.
  - abort in CALC or FIX: next edge goes to IDLE; hi/lo unchanged; no done pulse.
  - abort and start together in IDLE: abort wins, nothing starts.
  - mthi/mtlo: take effect at the edge only when in IDLE. They are ignored while busy; the hazard unit stalls them.
  - mthi/mtlo and start in the same IDLE cycle: the write is applied and the operation starts; the operation's later result overwrites.
  - mthi and mtlo together: both registers written.
  - Reset mid-operation: immediate return to the reset state.
- hi/lo are plain register outputs; MFHI/MFLO read them directly. The hazard unit must stall any MFHI/MFLO while busy=1.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: for MULT/MULTU, if the remaining unshifted multiplier magnitude is zero at any CALC cycle, the accumulator is aligned by the remaining shift count and the state moves to FIX on the next edge.
  - Latency becomes variable; minimum is 3 cycles from start to done (multiplier 0).
  - Divide is unaffected.
- Not defined: fixed WIDTH-iteration latency for all operations.

Test Plan:
- Reset then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 33 cycles; done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100 b=7 -> lo=14, hi=2.
- DIV a=5 b=0 -> done in cycle 2; hi=5, lo=0xFFFFFFFF.
- mthi wdata=0x1234 then MULT 2*3 with abort asserted at cycle 10 -> busy drops cycle 11; no done; hi=0x1234, lo unchanged. start asserted at cycle 5 of a running op is ignored.
- rst_n pulsed low mid-CALC -> busy=0, hi=lo=0 asynchronously. With MULDIV_EARLY_TERM_EN: MULTU a=9 b=1 -> done well before cycle 34; hi=0, lo=9.
